event_detect_peak: RTL

- Parametrised successor to the single-threshold ADC event detector; sits between the ADC sample interface and event logging/telemetry.
- Detects a rising step between consecutive samples that exceeds a runtime-programmable threshold, then tracks the pulse to its peak.
- Reports peak, baseline and amplitude for each event, with rise timeout, post-event holdoff and a saturating event counter.

---
 rtl/event_detect_peak.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/event_detect_peak.sv
// Step-triggered ADC event detector: arms on a baseline, triggers on a rising step above threshold, reports the pulse peak.
// Latency: event/timeout pulses and event_* data appear one clock after the sample strobe; no backpressure (one sample per valid edge).
module event_detect_peak #(
    parameter int DATA_WIDTH      = 24,
    parameter int COUNT_WIDTH     = 16,
    parameter int HOLDOFF_SAMPLES = 4,
    parameter int TIMEOUT_SAMPLES = 64
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic                         adc_count_valid,
    input  logic signed [DATA_WIDTH-1:0] adc_count,
    input  logic        [DATA_WIDTH-1:0] rise_threshold,
    output logic                         event_detected,
    output logic                         event_timeout,
    output logic signed [DATA_WIDTH-1:0] event_peak,
    output logic signed [DATA_WIDTH-1:0] event_baseline,
    output logic signed [DATA_WIDTH:0]   event_amplitude,
    output logic        [COUNT_WIDTH-1:0] event_count,
    output logic                         busy
);

    localparam int RC_W = $clog2(TIMEOUT_SAMPLES + 1);
    localparam int HC_W = (HOLDOFF_SAMPLES < 2) ? 1 : $clog2(HOLDOFF_SAMPLES);

    typedef enum logic [1:0] {IDLE, ARMED, RISE, HOLDOFF} state_t;

    // With no holdoff configured the detector re-arms straight after an event.
    localparam state_t POST_EVENT = (HOLDOFF_SAMPLES == 0) ? ARMED : HOLDOFF;

    state_t                         state_q, state_d;
    logic                           valid_q, valid_d;
    logic signed [DATA_WIDTH-1:0]   last_q, last_d;
    logic signed [DATA_WIDTH-1:0]   peak_q, peak_d;
    logic signed [DATA_WIDTH-1:0]   base_q, base_d;
    logic        [RC_W-1:0]         rise_cnt_q, rise_cnt_d;
    logic        [HC_W-1:0]         hold_cnt_q, hold_cnt_d;
    logic                           det_q, det_d;
    logic                           tmo_q, tmo_d;
    logic signed [DATA_WIDTH-1:0]   ev_peak_q, ev_peak_d;
    logic signed [DATA_WIDTH-1:0]   ev_base_q, ev_base_d;
    logic signed [DATA_WIDTH:0]     ev_amp_q, ev_amp_d;
    logic        [COUNT_WIDTH-1:0]  count_q, count_d;

    logic                           strobe;
    logic signed [DATA_WIDTH:0]     diff;
    logic signed [DATA_WIDTH:0]     thr_ext;
    logic signed [DATA_WIDTH:0]     amp;

    // One extra bit so full-scale swings cannot wrap.
    assign strobe  = adc_count_valid & ~valid_q;
    assign diff    = {adc_count[DATA_WIDTH-1], adc_count} - {last_q[DATA_WIDTH-1], last_q};
    assign thr_ext = $signed({1'b0, rise_threshold});
    assign amp     = {peak_q[DATA_WIDTH-1], peak_q} - {base_q[DATA_WIDTH-1], base_q};

    always_comb begin
        state_d    = state_q;
        valid_d    = adc_count_valid;
        last_d     = last_q;
        peak_d     = peak_q;
        base_d     = base_q;
        rise_cnt_d = rise_cnt_q;
        hold_cnt_d = hold_cnt_q;
        det_d      = 1'b0;
        tmo_d      = 1'b0;
        ev_peak_d  = ev_peak_q;
        ev_base_d  = ev_base_q;
        ev_amp_d   = ev_amp_q;
        count_d    = count_q;

        if (!enable) begin
            state_d = IDLE;
        end else if (strobe) begin
            last_d = adc_count;
            case (state_q)
                IDLE: state_d = ARMED;
                ARMED: begin
                    if (diff > thr_ext) begin
                        base_d     = last_q;
                        peak_d     = adc_count;
                        rise_cnt_d = RC_W'(1);
                        state_d    = RISE;
                    end
                end
                RISE: begin
                    if (adc_count < peak_q) begin
                        det_d      = 1'b1;
                        ev_peak_d  = peak_q;
                        ev_base_d  = base_q;
                        ev_amp_d   = amp;
                        if (count_q != {COUNT_WIDTH{1'b1}})
                            count_d = count_q + COUNT_WIDTH'(1);
                        hold_cnt_d = '0;
                        state_d    = POST_EVENT;
                    end else if (rise_cnt_q == RC_W'(TIMEOUT_SAMPLES)) begin
                        tmo_d      = 1'b1;
                        hold_cnt_d = '0;
                        state_d    = POST_EVENT;
                    end else begin
                        peak_d     = adc_count;
                        rise_cnt_d = rise_cnt_q + RC_W'(1);
                    end
                end
                HOLDOFF: begin
                    if (hold_cnt_q == HC_W'(HOLDOFF_SAMPLES - 1))
                        state_d = ARMED;
                    else
                        hold_cnt_d = hold_cnt_q + HC_W'(1);
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            valid_q    <= 1'b0;
            last_q     <= '0;
            peak_q     <= '0;
            base_q     <= '0;
            rise_cnt_q <= '0;
            hold_cnt_q <= '0;
            det_q      <= 1'b0;
            tmo_q      <= 1'b0;
            ev_peak_q  <= '0;
            ev_base_q  <= '0;
            ev_amp_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            peak_q     <= peak_d;
            base_q     <= base_d;
            rise_cnt_q <= rise_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            det_q      <= det_d;
            tmo_q      <= tmo_d;
            ev_peak_q  <= ev_peak_d;
            ev_base_q  <= ev_base_d;
            ev_amp_q   <= ev_amp_d;
            count_q    <= count_d;
        end
    end

    assign event_detected  = det_q;
    assign event_timeout   = tmo_q;
    assign event_peak      = ev_peak_q;
    assign event_baseline  = ev_base_q;
    assign event_amplitude = ev_amp_q;
    assign event_count     = count_q;
    assign busy            = (state_q == RISE) || (state_q == HOLDOFF);

endmodule
